// File: rtl/frame_drain_pkg.sv
// Shared types and constants for the frame drain controller.
//
// Contents:
//   drain_state_e   - controller FSM states
//   FRAME_CNT_W     - width of the completed-frame counter
//   GAP_CNT_W       - width of the inter-frame gap counter (GAP_CYC <= 15)
//   *_RST           - reset values for the controller registers
//   frame_cnt_inc() - wrapping increment for the frame counter
package frame_drain_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StXfer = 3'd2,
    StGap  = 3'd3,
    StErr  = 3'd4
  } drain_state_e;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned GAP_CNT_W   = 4;

  localparam drain_state_e            DRAIN_STATE_RST = StIdle;
  localparam logic                    ERR_RST         = 1'b0;
  localparam logic [FRAME_CNT_W-1:0]  FRAME_CNT_RST   = '0;
  localparam logic [GAP_CNT_W-1:0]    GAP_CNT_RST     = '0;

  // 0xFFFF + 1 wraps to 0 by truncation.
  function automatic logic [FRAME_CNT_W-1:0] frame_cnt_inc(input logic [FRAME_CNT_W-1:0] cnt);
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/frame_drain_pipe.sv
// Two-stage read pipeline between the async FIFO read port and the sync FIFO write port.
//
// A pop at cycle t enters stage 1 as valid/sop/eop tags. At t+1 the async FIFO read data is
// valid and is captured together with the tags into stage 2, which drives the sync FIFO
// write at t+2. No backpressure: every accepted pop is written exactly two cycles later.
//
// Ports:
//   clk_i, rst_ni     - clock, synchronous active-low reset (pipeline reset to empty)
//   pop_i             - a word is being popped from the async FIFO this cycle
//   sop_i, eop_i      - frame tags of the word being popped
//   rd_data_i         - async FIFO read data (valid the cycle after the pop)
//   s1_valid_o        - stage 1 holds an in-flight word
//   wr_en_o           - sync FIFO write strobe
//   wr_data_o         - sync FIFO write data
//   sop_o, eop_o      - frame tags, already qualified by wr_en_o
module frame_drain_pipe #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pop_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              s1_valid_o,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              sop_o,
  output logic              eop_o
);

  logic              s1_valid_q, s1_sop_q, s1_eop_q;
  logic              s2_valid_q, s2_sop_q, s2_eop_q;
  logic [DATA_W-1:0] s2_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      // Tags are masked with the valid so they never leak on idle cycles.
      s1_valid_q <= pop_i;
      s1_sop_q   <= pop_i & sop_i;
      s1_eop_q   <= pop_i & eop_i;
      s2_valid_q <= s1_valid_q;
      s2_sop_q   <= s1_sop_q;
      s2_eop_q   <= s1_eop_q;
      if (s1_valid_q) begin
        s2_data_q <= rd_data_i;
      end
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign wr_en_o    = s2_valid_q;
  assign wr_data_o  = s2_data_q;
  assign sop_o      = s2_sop_q;
  assign eop_o      = s2_eop_q;

endmodule

// File: rtl/frame_drain_ctrl.sv
// Frame-level drain controller: moves whole frames from the async (CDC) FIFO into the sync
// output FIFO, tagging the first and last word with out_sop / out_eop.
//
// A frame is only started once the async FIFO holds FRAME_LEN words, so a started frame can
// never starve. Pops are throttled by sync_almost_full; any FIFO overflow/underflow pulse
// parks the controller in an error state until enable is dropped.
//
// Optional feature: define FRAME_DRAIN_STATS_EN to build the 16-bit completed-frame counter.
// Without it frame_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   enable               - start/continue framing; dropping it also clears an error
//   async_fifo_empty     - async FIFO empty flag
//   async_rd_lvl         - async FIFO read-side fill level
//   async_fifo_rd_data   - async FIFO read data, valid the cycle after async_fifo_rd_en
//   async_underflow      - async FIFO underflow pulse
//   async_fifo_rd_en     - async FIFO pop request
//   sync_almost_full     - sync FIFO has at most 2 free entries
//   sync_overflow        - sync FIFO overflow pulse
//   sync_wr_en           - sync FIFO write strobe
//   sync_wr_data         - sync FIFO write data
//   out_sop, out_eop     - first/last word of a frame, qualified by sync_wr_en
//   busy                 - controller not idle
//   err_sticky           - error latched
//   frame_cnt            - completed frame count (wraps)
module frame_drain_ctrl
  import frame_drain_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LVL_W     = 6,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   async_fifo_empty,
  input  logic [LVL_W-1:0]       async_rd_lvl,
  input  logic [DATA_W-1:0]      async_fifo_rd_data,
  input  logic                   async_underflow,
  output logic                   async_fifo_rd_en,
  input  logic                   sync_almost_full,
  input  logic                   sync_overflow,
  output logic                   sync_wr_en,
  output logic [DATA_W-1:0]      sync_wr_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   busy,
  output logic                   err_sticky,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0]     LEN_CNT  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0]     LEN_LVL  = LVL_W'(FRAME_LEN);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  drain_state_e         state_q, state_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic                 err_q, err_d;

  logic err_in;
  logic pop;
  logic pipe_s1_valid;
  logic xfer_done;

  assign err_in = sync_overflow | async_underflow;

  // An error pulse suppresses the pop of the same cycle, so a frame hit on its last pop
  // never produces an eop and is never counted.
  assign pop = (state_q == StXfer) && !err_in && !sync_almost_full && !async_fifo_empty &&
               (issued_q < LEN_CNT);

  // All pops issued and stage 1 empty; the final word is in stage 2 being written now.
  assign xfer_done = (issued_q == LEN_CNT) && !pipe_s1_valid;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    gap_d    = gap_q;
    err_d    = err_q;

    if (pop) begin
      issued_d = issued_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (async_rd_lvl >= LEN_LVL) begin
          state_d  = StXfer;
          issued_d = '0;
        end
      end
      StXfer: begin
        if (xfer_done) begin
          if (GAP_CYC == 0) begin
            state_d = enable ? StWait : StIdle;
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end
      end
      StGap: begin
        if (gap_q == GAP_LAST) begin
          state_d = enable ? StWait : StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StErr: begin
        if (!enable) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Errors win over every other transition, including leaving ERR.
    if (err_in) begin
      state_d = StErr;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DRAIN_STATE_RST;
      issued_q <= '0;
      gap_q    <= GAP_CNT_RST;
      err_q    <= ERR_RST;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
    end
  end

  frame_drain_pipe #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pop_i      (pop),
    .sop_i      (issued_q == '0),
    .eop_i      (issued_q == LAST_CNT),
    .rd_data_i  (async_fifo_rd_data),
    .s1_valid_o (pipe_s1_valid),
    .wr_en_o    (sync_wr_en),
    .wr_data_o  (sync_wr_data),
    .sop_o      (out_sop),
    .eop_o      (out_eop)
  );

  assign async_fifo_rd_en = pop;
  assign busy             = (state_q != StIdle);
  assign err_sticky       = err_q;

`ifdef FRAME_DRAIN_STATS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= FRAME_CNT_RST;
    end else if (sync_wr_en && out_eop) begin
      frame_cnt_q <= frame_cnt_inc(frame_cnt_q);
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = FRAME_CNT_RST;
`endif

endmodule

// File: tb/tb_frame_drain_ctrl.sv
// Bench for frame_drain_ctrl with FRAME_LEN=4, GAP_CYC=2. A queue models the async FIFO
// (level, empty, one-cycle read latency); monitors log every pop and every sync FIFO write,
// and each scenario task compares the logs with the words it pushed and the frame rules.
module tb_frame_drain_ctrl;

  localparam int DW = 32;
  localparam int LW = 6;
  localparam int FL = 4;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          async_fifo_empty = 1'b1;
  logic [LW-1:0] async_rd_lvl = '0;
  logic [DW-1:0] async_fifo_rd_data = '0;
  logic          async_underflow = 1'b0;
  logic          async_fifo_rd_en;
  logic          sync_almost_full = 1'b0;
  logic          sync_overflow = 1'b0;
  logic          sync_wr_en;
  logic [DW-1:0] sync_wr_data;
  logic          out_sop;
  logic          out_eop;
  logic          busy;
  logic          err_sticky;
  logic [15:0]   frame_cnt;

  frame_drain_ctrl #(
    .DATA_W    (DW),
    .LVL_W     (LW),
    .FRAME_LEN (FL),
    .GAP_CYC   (GC)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .async_fifo_empty   (async_fifo_empty),
    .async_rd_lvl       (async_rd_lvl),
    .async_fifo_rd_data (async_fifo_rd_data),
    .async_underflow    (async_underflow),
    .async_fifo_rd_en   (async_fifo_rd_en),
    .sync_almost_full   (sync_almost_full),
    .sync_overflow      (sync_overflow),
    .sync_wr_en         (sync_wr_en),
    .sync_wr_data       (sync_wr_data),
    .out_sop            (out_sop),
    .out_eop            (out_eop),
    .busy               (busy),
    .err_sticky         (err_sticky),
    .frame_cnt          (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [DW-1:0] d;
    bit          sop;
    bit          eop;
  } wr_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            frames_done = 0;
  int            af_pop_viol = 0;
  bit            pop_seen = 1'b0;
  logic [DW-1:0] fifo_q[$];
  wr_t           wr_log[$];
  int            pop_log[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Async FIFO model: data for a pop appears the cycle after it; level follows the queue.
  initial forever begin
    @(posedge clk);
    #2;
    if (pop_seen && fifo_q.size() > 0) async_fifo_rd_data = fifo_q.pop_front();
    async_rd_lvl     = (fifo_q.size() > 63) ? 6'd63 : LW'(fifo_q.size());
    async_fifo_empty = (fifo_q.size() == 0);
  end

  initial forever begin
    @(negedge clk);
    pop_seen = async_fifo_rd_en;
    if (async_fifo_rd_en) begin
      pop_log.push_back(cyc);
      if (sync_almost_full) af_pop_viol++;
    end
    if (sync_wr_en) wr_log.push_back('{cyc, sync_wr_data, out_sop, out_eop});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_fc();
`ifdef FRAME_DRAIN_STATS_EN
    return 16'(frames_done);
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    pop_log.delete();
    af_pop_viol = 0;
  endtask

  task automatic push_words(input int n, inout logic [DW-1:0] w[$]);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = $urandom();
      w.push_back(v);
      fifo_q.push_back(v);
    end
  endtask

  task automatic wait_writes(input int n, input int limit, output bit ok);
    for (int i = 0; i < limit && wr_log.size() < n; i++) @(negedge clk);
    ok = (wr_log.size() >= n);
  endtask

  task automatic wait_pops(input int n, input int limit, output bit ok);
    for (int i = 0; i < limit && pop_log.size() < n; i++) @(negedge clk);
    ok = (pop_log.size() >= n);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    for (int i = 0; i < limit && busy !== 1'b0; i++) @(negedge clk);
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({async_fifo_rd_en, sync_wr_en, out_sop, out_eop, busy, err_sticky} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {async_fifo_rd_en, sync_wr_en, out_sop, out_eop, busy, err_sticky});
    end
    checks++;
    if (sync_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", sync_wr_data);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] w[$];
    bit ok;
    int t_en;
    clear_logs();
    push_words(FL, w);
    enable = 1'b1;
    t_en = cyc;
    wait_writes(FL, 40, ok);
    repeat (4) @(negedge clk);
    frames_done++;
    checks++;
    if (!ok || wr_log.size() != FL || pop_log.size() != FL) begin
      errors++;
      $display("FAIL single_count: got writes=%0d pops=%0d expected %0d", wr_log.size(),
               pop_log.size(), FL);
    end else begin
      checks++;
      if (pop_log[0] != t_en + 2) begin
        errors++;
        $display("FAIL single_first_pop: got cycle %0d expected %0d", pop_log[0], t_en + 2);
      end
      for (int i = 0; i < FL; i++) begin
        checks++;
        if (pop_log[i] != pop_log[0] + i || wr_log[i].cyc != pop_log[i] + 2) begin
          errors++;
          $display("FAIL single_timing%0d: got pop=%0d wr=%0d expected pop=%0d wr=%0d", i,
                   pop_log[i], wr_log[i].cyc, pop_log[0] + i, pop_log[0] + i + 2);
        end
        checks++;
        if (wr_log[i].d !== w[i] || wr_log[i].sop !== (i == 0) || wr_log[i].eop !== (i == FL-1))
        begin
          errors++;
          $display("FAIL single_word%0d: got d=%h sop=%0b eop=%0b expected d=%h sop=%0b eop=%0b",
                   i, wr_log[i].d, wr_log[i].sop, wr_log[i].eop, w[i], i == 0, i == FL-1);
        end
      end
    end
    checks++;
    if (frame_cnt !== exp_fc()) begin
      errors++;
      $display("FAIL single_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc());
    end
    tick();
    enable = 1'b0;
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_insufficient_level();
    logic [DW-1:0] w[$];
    bit ok;
    int c;
    clear_logs();
    push_words(FL - 1, w);
    enable = 1'b1;
    repeat (20) tick();
    checks++;
    if (pop_log.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL low_level_hold: got pops=%0d busy=%b expected pops=0 busy=1",
               pop_log.size(), busy);
    end
    c = cyc;
    push_words(1, w);
    wait_writes(FL, 40, ok);
    repeat (4) @(negedge clk);
    frames_done++;
    checks++;
    if (!ok || pop_log.size() != FL || wr_log.size() != FL) begin
      errors++;
      $display("FAIL low_level_count: got pops=%0d writes=%0d expected %0d", pop_log.size(),
               wr_log.size(), FL);
    end else begin
      checks++;
      if (pop_log[0] != c + 1) begin
        errors++;
        $display("FAIL low_level_first_pop: got cycle %0d expected %0d", pop_log[0], c + 1);
      end
      for (int i = 0; i < FL; i++) begin
        checks++;
        if (wr_log[i].d !== w[i] || wr_log[i].sop !== (i == 0) || wr_log[i].eop !== (i == FL-1))
        begin
          errors++;
          $display("FAIL low_level_word%0d: got d=%h expected d=%h", i, wr_log[i].d, w[i]);
        end
      end
    end
    tick();
    enable = 1'b0;
    wait_idle(20, ok);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[$];
    bit ok;
    clear_logs();
    push_words(2 * FL, w);
    enable = 1'b1;
    wait_writes(2 * FL, 80, ok);
    repeat (4) @(negedge clk);
    frames_done += 2;
    checks++;
    if (!ok || wr_log.size() != 2 * FL || pop_log.size() != 2 * FL) begin
      errors++;
      $display("FAIL b2b_count: got writes=%0d pops=%0d expected %0d", wr_log.size(),
               pop_log.size(), 2 * FL);
    end else begin
      checks++;
      if (pop_log[FL] != wr_log[FL-1].cyc + GC + 2) begin
        errors++;
        $display("FAIL b2b_gap: got next pop %0d expected %0d", pop_log[FL],
                 wr_log[FL-1].cyc + GC + 2);
      end
      for (int i = 0; i < 2 * FL; i++) begin
        checks++;
        if (wr_log[i].d !== w[i] || wr_log[i].sop !== (i % FL == 0) ||
            wr_log[i].eop !== (i % FL == FL-1) || wr_log[i].cyc != pop_log[i] + 2) begin
          errors++;
          $display("FAIL b2b_word%0d: got d=%h sop=%0b eop=%0b cyc=%0d expected d=%h cyc=%0d",
                   i, wr_log[i].d, wr_log[i].sop, wr_log[i].eop, wr_log[i].cyc, w[i],
                   pop_log[i] + 2);
        end
      end
    end
    checks++;
    if (frame_cnt !== exp_fc()) begin
      errors++;
      $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc());
    end
    tick();
    enable = 1'b0;
    wait_idle(20, ok);
  endtask

  task automatic test_throttle();
    logic [DW-1:0] w[$];
    bit ok;
    int h, p2, nsop, neop;
    h = $urandom_range(3, 7);
    clear_logs();
    push_words(FL, w);
    enable = 1'b1;
    wait_pops(2, 40, ok);
    p2 = ok ? pop_log[1] : 0;
    tick();
    sync_almost_full = 1'b1;
    repeat (h) tick();
    sync_almost_full = 1'b0;
    wait_writes(FL, 40, ok);
    repeat (4) @(negedge clk);
    frames_done++;
    checks++;
    if (!ok || pop_log.size() != FL || wr_log.size() != FL) begin
      errors++;
      $display("FAIL throttle_count: got pops=%0d writes=%0d expected %0d", pop_log.size(),
               wr_log.size(), FL);
    end else begin
      checks++;
      if (pop_log[2] != p2 + 1 + h || pop_log[3] != p2 + 2 + h) begin
        errors++;
        $display("FAIL throttle_resume: got pops %0d,%0d expected %0d,%0d", pop_log[2],
                 pop_log[3], p2 + 1 + h, p2 + 2 + h);
      end
      checks++;
      if (wr_log[1].cyc != p2 + 2) begin
        errors++;
        $display("FAIL throttle_inflight: got write cycle %0d expected %0d", wr_log[1].cyc,
                 p2 + 2);
      end
      nsop = 0;
      neop = 0;
      for (int i = 0; i < FL; i++) begin
        nsop += int'(wr_log[i].sop);
        neop += int'(wr_log[i].eop);
        checks++;
        if (wr_log[i].d !== w[i]) begin
          errors++;
          $display("FAIL throttle_word%0d: got %h expected %h", i, wr_log[i].d, w[i]);
        end
      end
      checks++;
      if (nsop != 1 || neop != 1 || wr_log[0].sop !== 1'b1 || wr_log[FL-1].eop !== 1'b1) begin
        errors++;
        $display("FAIL throttle_tags: got sop=%0d eop=%0d expected 1 and 1", nsop, neop);
      end
    end
    checks++;
    if (af_pop_viol != 0) begin
      errors++;
      $display("FAIL throttle_af_pop: got %0d pops under almost-full expected 0", af_pop_viol);
    end
    tick();
    enable = 1'b0;
    wait_idle(20, ok);
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] w[$];
    bit ok;
    int nf, n;
    nf = $urandom_range(3, 5);
    n  = nf * FL;
    clear_logs();
    push_words(n, w);
    enable = 1'b1;
    for (int k = 0; k < 600 && wr_log.size() < n; k++) begin
      tick();
      sync_almost_full = ($urandom_range(0, 2) == 0);
    end
    sync_almost_full = 1'b0;
    repeat (4) @(negedge clk);
    frames_done += nf;
    checks++;
    if (wr_log.size() != n || pop_log.size() != n) begin
      errors++;
      $display("FAIL rand_count: got writes=%0d pops=%0d expected %0d", wr_log.size(),
               pop_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_log[i].d !== w[i] || wr_log[i].sop !== (i % FL == 0) ||
            wr_log[i].eop !== (i % FL == FL-1) || wr_log[i].cyc != pop_log[i] + 2) begin
          errors++;
          $display("FAIL rand_word%0d: got d=%h sop=%0b eop=%0b cyc=%0d expected d=%h cyc=%0d",
                   i, wr_log[i].d, wr_log[i].sop, wr_log[i].eop, wr_log[i].cyc, w[i],
                   pop_log[i] + 2);
        end
      end
    end
    checks++;
    if (af_pop_viol != 0) begin
      errors++;
      $display("FAIL rand_af_pop: got %0d pops under almost-full expected 0", af_pop_viol);
    end
    checks++;
    if (frame_cnt !== exp_fc()) begin
      errors++;
      $display("FAIL rand_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc());
    end
    tick();
    enable = 1'b0;
    wait_idle(20, ok);
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] w[$];
    bit ok;
    clear_logs();
    push_words(FL, w);
    enable = 1'b1;
    wait_pops(1, 40, ok);
    tick();
    enable = 1'b0;
    wait_writes(FL, 40, ok);
    wait_idle(40, ok);
    repeat (4) @(negedge clk);
    frames_done++;
    checks++;
    if (wr_log.size() != FL || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_complete: got writes=%0d busy=%b expected %0d and 0", wr_log.size(),
               busy, FL);
    end else begin
      for (int i = 0; i < FL; i++) begin
        checks++;
        if (wr_log[i].d !== w[i] || wr_log[i].sop !== (i == 0) || wr_log[i].eop !== (i == FL-1))
        begin
          errors++;
          $display("FAIL drop_word%0d: got d=%h eop=%0b expected d=%h eop=%0b", i, wr_log[i].d,
                   wr_log[i].eop, w[i], i == FL-1);
        end
      end
    end
    checks++;
    if (frame_cnt !== exp_fc()) begin
      errors++;
      $display("FAIL drop_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc());
    end
  endtask

  task automatic test_error();
    logic [DW-1:0] w[$];
    bit ok, use_uf;
    use_uf = $urandom_range(0, 1) == 1;
    clear_logs();
    push_words(FL, w);
    enable = 1'b1;
    wait_pops(2, 40, ok);
    tick();
    if (use_uf) async_underflow = 1'b1;
    else sync_overflow = 1'b1;
    tick();
    async_underflow = 1'b0;
    sync_overflow   = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_latch: got err=%b busy=%b expected 1 1", err_sticky, busy);
    end
    checks++;
    if (pop_log.size() != 2) begin
      errors++;
      $display("FAIL err_no_pop: got %0d pops expected 2", pop_log.size());
    end
    checks++;
    if (wr_log.size() != 2 || (wr_log.size() == 2 && (wr_log[0].d !== w[0] ||
        wr_log[1].d !== w[1] || wr_log[1].eop !== 1'b0))) begin
      errors++;
      $display("FAIL err_drain: got %0d writes expected 2 in-flight words without eop",
               wr_log.size());
    end
    tick();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_exit: got err=%b busy=%b expected 0 0", err_sticky, busy);
    end
    checks++;
    if (frame_cnt !== exp_fc()) begin
      errors++;
      $display("FAIL err_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc());
    end
    fifo_q.delete();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w[$];
    bit ok;
    int n_rel;
    clear_logs();
    push_words(FL, w);
    enable = 1'b1;
    wait_pops(2, 40, ok);
    tick();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({async_fifo_rd_en, sync_wr_en, out_sop, out_eop, busy, err_sticky} !== 6'b0 ||
        sync_wr_data !== '0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ctrl=%b data=%h cnt=%0d expected all 0",
               {async_fifo_rd_en, sync_wr_en, out_sop, out_eop, busy, err_sticky},
               sync_wr_data, frame_cnt);
    end
    frames_done = 0;
    enable = 1'b0;
    fifo_q.delete();
    tick();
    rst_n = 1'b1;
    n_rel = wr_log.size();
    repeat (15) tick();
    @(negedge clk);
    checks++;
    if (wr_log.size() != n_rel || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_eop: got %0d writes after release busy=%b expected 0 0",
               wr_log.size() - n_rel, busy);
    end
    for (int i = 0; i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i].eop !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_eop%0d: got eop=1 expected 0", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_insufficient_level();
    test_back_to_back();
    test_throttle();
    test_random_stream();
    test_enable_drop();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
